// File: rtl/pool_pkg.sv
// Shared widths and defaults for the block pooling downsampler.
// Grid indices are 5 bits, enough for a 32-column or 24-row grid.
package pool_pkg;

    localparam int DEF_BLOCK  = 10;
    localparam int DEF_OUT_W  = 32;
    localparam int DEF_OUT_H  = 24;
    localparam int DEF_THRESH = 50;

    localparam int CNT_W = $clog2(DEF_BLOCK * DEF_BLOCK + 1);
    localparam int IDX_W = 5;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/raster_tile_tracker.sv
// Follows the raster position of the pixel stream and reports, per valid
// pixel, which grid tile it belongs to and whether it opens or closes it.
module raster_tile_tracker
    import pool_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK,
    parameter int OUT_W = DEF_OUT_W,
    parameter int OUT_H = DEF_OUT_H
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [10:0] hcount_i,
    input  logic [9:0]  vcount_i,
    input  logic        valid_i,
    output logic        pix_ok_o,
    output logic        tile_first_o,
    output logic        tile_last_o,
    output idx_t        h_blk_o,
    output idx_t        v_blk_o
);

    localparam int SUB_W = (BLOCK > 1) ? $clog2(BLOCK) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(BLOCK - 1);

    logic             synced_q;
    logic [SUB_W-1:0] h_sub_q, h_sub_d;
    logic [SUB_W-1:0] v_sub_q, v_sub_d;
    idx_t             h_blk_q, h_blk_d;
    idx_t             v_blk_q, v_blk_d;

    logic in_range;
    logic row_start;
    logic frame_start;

    assign in_range    = (hcount_i < 11'(BLOCK * OUT_W))
                      && (vcount_i < 10'(BLOCK * OUT_H));
    assign row_start   = (hcount_i == '0);
    assign frame_start = row_start && (vcount_i == '0);
    assign pix_ok_o    = valid_i && in_range && (synced_q || frame_start);

    // Indices of the current pixel, derived from the previous one.
    always_comb begin
        h_sub_d = h_sub_q;
        h_blk_d = h_blk_q;
        v_sub_d = v_sub_q;
        v_blk_d = v_blk_q;
        if (row_start) begin
            h_sub_d = '0;
            h_blk_d = '0;
            if (frame_start) begin
                v_sub_d = '0;
                v_blk_d = '0;
            end else if (v_sub_q == SUB_MAX) begin
                v_sub_d = '0;
                v_blk_d = v_blk_q + 1'b1;
            end else begin
                v_sub_d = v_sub_q + 1'b1;
            end
        end else if (h_sub_q == SUB_MAX) begin
            h_sub_d = '0;
            h_blk_d = h_blk_q + 1'b1;
        end else begin
            h_sub_d = h_sub_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            synced_q <= 1'b0;
            h_sub_q  <= '0;
            h_blk_q  <= '0;
            v_sub_q  <= '0;
            v_blk_q  <= '0;
        end else if (pix_ok_o) begin
            synced_q <= 1'b1;
            h_sub_q  <= h_sub_d;
            h_blk_q  <= h_blk_d;
            v_sub_q  <= v_sub_d;
            v_blk_q  <= v_blk_d;
        end
    end

    assign tile_first_o = pix_ok_o && (h_sub_d == '0) && (v_sub_d == '0);
    assign tile_last_o  = pix_ok_o && (h_sub_d == SUB_MAX)
                       && (v_sub_d == SUB_MAX);
    assign h_blk_o = h_blk_d;
    assign v_blk_o = v_blk_d;

endmodule

// File: rtl/block_pool_downsampler.sv
// Reduces a 1-bit raster to a grid of per-tile ones-counts and majority
// bits, emitting one registered cell as each tile's last pixel arrives.
module block_pool_downsampler
    import pool_pkg::*;
#(
    parameter int BLOCK  = DEF_BLOCK,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int OUT_H  = DEF_OUT_H,
    parameter int THRESH = DEF_THRESH
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        data_valid_in,
    input  logic        pixel_in,
    output logic        pixel_out,
    output logic [6:0]  count_out,
    output logic [4:0]  hcount_out,
    output logic [4:0]  vcount_out,
    output logic        data_valid_out,
    output logic        frame_done_out
);

    logic pix_ok;
    logic tile_first;
    logic tile_last;
    idx_t h_blk;
    idx_t v_blk;

    raster_tile_tracker #(
        .BLOCK(BLOCK),
        .OUT_W(OUT_W),
        .OUT_H(OUT_H)
    ) u_tracker (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .hcount_i    (hcount_in),
        .vcount_i    (vcount_in),
        .valid_i     (data_valid_in),
        .pix_ok_o    (pix_ok),
        .tile_first_o(tile_first),
        .tile_last_o (tile_last),
        .h_blk_o     (h_blk),
        .v_blk_o     (v_blk)
    );

    cnt_t acc_q [OUT_W];
    cnt_t sum;
    logic emit;

    // A tile's first pixel overwrites the slot, so no clear pass is needed.
    assign sum  = (tile_first ? cnt_t'(0) : acc_q[h_blk]) + cnt_t'(pixel_in);
    assign emit = pix_ok && tile_last;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < OUT_W; i++) begin
                acc_q[i] <= '0;
            end
        end else if (pix_ok) begin
            acc_q[h_blk] <= sum;
        end
    end

    logic pixel_q, pixel_d;
    cnt_t count_q, count_d;
    idx_t hcnt_q, hcnt_d;
    idx_t vcnt_q, vcnt_d;
    logic valid_q, valid_d;
    logic done_q, done_d;

    always_comb begin
        pixel_d = pixel_q;
        count_d = count_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        valid_d = emit;
        done_d  = emit && (h_blk == IDX_W'(OUT_W - 1))
                       && (v_blk == IDX_W'(OUT_H - 1));
        if (emit) begin
            pixel_d = (sum >= cnt_t'(THRESH));
            count_d = sum;
            hcnt_d  = h_blk;
            vcnt_d  = v_blk;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pixel_q <= 1'b0;
            count_q <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pixel_q <= pixel_d;
            count_q <= count_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign pixel_out      = pixel_q;
    assign count_out      = count_q;
    assign hcount_out     = hcnt_q;
    assign vcount_out     = vcnt_q;
    assign data_valid_out = valid_q;
    assign frame_done_out = done_q;

endmodule

// File: tb/tb_block_pool_downsampler.sv
// Directed bench: two instances (THRESH 50 and 51) fed the same stream,
// every cycle's outputs compared against hand-derived tile expectations.
module tb_block_pool_downsampler;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        data_valid_in;
    logic        pixel_in;

    logic       a_pix, b_pix;
    logic [6:0] a_cnt, b_cnt;
    logic [4:0] a_h, b_h, a_v, b_v;
    logic       a_dv, b_dv, a_fd, b_fd;

    int total = 0;
    int bad   = 0;
    int mode  = 0;
    bit armed = 1'b0;
    int last_c = 0;
    int last_h = 0;
    int last_v = 0;

    always #5 clk = ~clk;

    block_pool_downsampler #(.THRESH(50)) dut_a (
        .clk_in(clk), .rst_in(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .data_valid_in(data_valid_in), .pixel_in(pixel_in),
        .pixel_out(a_pix), .count_out(a_cnt),
        .hcount_out(a_h), .vcount_out(a_v),
        .data_valid_out(a_dv), .frame_done_out(a_fd)
    );

    block_pool_downsampler #(.THRESH(51)) dut_b (
        .clk_in(clk), .rst_in(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .data_valid_in(data_valid_in), .pixel_in(pixel_in),
        .pixel_out(b_pix), .count_out(b_cnt),
        .hcount_out(b_h), .vcount_out(b_v),
        .data_valid_out(b_dv), .frame_done_out(b_fd)
    );

    // Modes: 0 all ones, 1 checkerboard, 2 only tile (5,3), 3 column ramp.
    function automatic bit pat(input int m, input int h, input int v);
        case (m)
            0: return 1'b1;
            1: return bit'((h + v) & 1);
            2: return (h >= 50 && h <= 59 && v >= 30 && v <= 39);
            default: return ((h % 10) < ((h / 10) % 11));
        endcase
    endfunction

    function automatic int expc(input int m, input int hb, input int vb);
        case (m)
            0: return 100;
            1: return 50;
            2: return (hb == 5 && vb == 3) ? 100 : 0;
            default: return 10 * (hb % 11);
        endcase
    endfunction

    task automatic cmp(input string tag, input logic [19:0] obs,
                       input logic [19:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check(input bit emit, input int hb, input int vb);
        logic [19:0] ea, eb;
        bit fd;
        if (emit) begin
            last_c = expc(mode, hb, vb);
            last_h = hb;
            last_v = vb;
        end
        fd = emit && hb == 31 && vb == 23;
        ea = {(last_c >= 50), 7'(last_c), 5'(last_h), 5'(last_v), emit, fd};
        eb = {(last_c >= 51), 7'(last_c), 5'(last_h), 5'(last_v), emit, fd};
        cmp("cellA", {a_pix, a_cnt, a_h, a_v, a_dv, a_fd}, ea);
        cmp("cellB", {b_pix, b_cnt, b_h, b_v, b_dv, b_fd}, eb);
    endtask

    task automatic pix(input int h, input int v, input bit p);
        bit inr, emit;
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        pixel_in      = p;
        data_valid_in = 1'b1;
        inr = (h < 320) && (v < 240);
        if (inr && h == 0 && v == 0) armed = 1'b1;
        emit = armed && inr && (h % 10 == 9) && (v % 10 == 9);
        @(posedge clk);
        @(negedge clk);
        data_valid_in = 1'b0;
        check(emit, h / 10, v / 10);
    endtask

    // Idle cycles carry a frame-start lookalike that must be ignored.
    task automatic idle();
        data_valid_in = 1'b0;
        hcount_in     = '0;
        vcount_in     = '0;
        pixel_in      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check(1'b0, 0, 0);
    endtask

    task automatic row(input int v, input bit gaps);
        for (int h = 0; h < 320; h++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle();
            pix(h, v, pat(mode, h, v));
        end
    endtask

    task automatic do_reset();
        data_valid_in = 1'b0;
        rst = 1'b1;
        armed  = 1'b0;
        last_c = 0;
        last_h = 0;
        last_v = 0;
        #1;
        check(1'b0, 0, 0);
        repeat (2) @(negedge clk);
        check(1'b0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        data_valid_in = 1'b0;
        hcount_in = '0;
        vcount_in = '0;
        pixel_in  = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Nothing counts before the first valid (0,0).
        pix(5, 0, 1'b1);
        pix(9, 9, 1'b1);
        pix(1, 2, 1'b0);
        idle();
        pix(9, 9, 1'b1);

        // Column ramp with random gaps and out-of-range injections.
        mode = 3;
        for (int v = 0; v < 10; v++) begin
            row(v, 1'b1);
            if (v == 4) begin
                for (int h = 320; h <= 330; h++) pix(h, 4, 1'b1);
                for (int h = 0; h <= 10; h++) pix(h, 240, 1'b1);
            end
        end

        // Early restart into a checkerboard band.
        mode = 1;
        for (int v = 0; v < 10; v++) row(v, 1'b0);

        // Single lit tile (5,3); upper rows fed as row-start pixels only.
        mode = 2;
        for (int v = 0; v < 30; v++) pix(0, v, 1'b0);
        for (int v = 30; v < 40; v++) row(v, 1'b0);

        // Reset mid-frame, stream resumes, then a fresh frame.
        mode = 0;
        for (int v = 0; v < 7; v++) pix(0, v, 1'b1);
        for (int h = 0; h < 100; h++) pix(h, 7, 1'b1);
        do_reset();
        for (int v = 8; v < 10; v++) row(v, 1'b0);
        mode = 1;
        for (int v = 0; v < 10; v++) row(v, 1'b0);

        // Bottom of an all-ones frame, ending on frame_done.
        mode = 0;
        for (int v = 0; v < 220; v++) pix(0, v, 1'b1);
        for (int v = 220; v < 240; v++) row(v, 1'b0);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
